// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and entry type for the instruction fetch unit
package fetch_pkg;
  localparam int INST_BYTES = 4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0040_0000;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: program-memory and decode-side signals of the fetch unit
interface instruction_fetch_unit_if #(parameter int DATA_WIDTH = 32);
  logic [DATA_WIDTH-1:0] Address_o, Instruction_i, Redirect_Target_i, Inst_o, Inst_PC_o;
  logic Redirect_i, Inst_Valid_o, Inst_Ready_i, Misaligned_o;
  modport master (
    output Address_o, Inst_Valid_o, Inst_o, Inst_PC_o, Misaligned_o,
    input  Instruction_i, Redirect_i, Redirect_Target_i, Inst_Ready_i
  );
  modport slave (
    input  Address_o, Inst_Valid_o, Inst_o, Inst_PC_o, Misaligned_o,
    output Instruction_i, Redirect_i, Redirect_Target_i, Inst_Ready_i
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush; push and pop may coincide when full
module fetch_fifo #(
  parameter int W = 64,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) mem[wp] <= din;
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  assign valid = count != '0;
  assign full = count == (AW+1)'(DEPTH);
  assign dout = valid ? mem[rp] : '0;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC, redirect and buffered hand-off of fetched instructions to decode.
// Define FETCH_MISALIGN_CHECK_EN to halt on a misaligned redirect target.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int FIFO_DEPTH = 2
) (
  input logic clk,
  input logic reset,
  instruction_fetch_unit_if.master bus
);
  logic [DATA_WIDTH-1:0] pc, tgt;
  logic halted, pop, push, full, valid;
  assign pop = valid && bus.Inst_Ready_i;
  assign push = !bus.Redirect_i && !halted && (!full || pop);
  assign bus.Address_o = pc;
  assign bus.Inst_Valid_o = valid;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic mis;
  always_ff @(posedge clk) begin
    if (reset) mis <= 1'b0;
    else if (bus.Redirect_i && |bus.Redirect_Target_i[1:0]) mis <= 1'b1;
  end
  assign tgt = bus.Redirect_Target_i;
  assign halted = mis;
  assign bus.Misaligned_o = mis;
`else
  assign tgt = {bus.Redirect_Target_i[DATA_WIDTH-1:2], 2'b00};
  assign halted = 1'b0;
  assign bus.Misaligned_o = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) pc <= RESET_VECTOR;
    else if (bus.Redirect_i) pc <= tgt;
    else if (push) pc <= pc + DATA_WIDTH'(INST_BYTES);
  end
  // redirect flushes the buffer, so a head accepted in that cycle is dropped
  fetch_fifo #(.W(2*DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(reset),
    .flush(bus.Redirect_i),
    .push(push),
    .pop(pop),
    .din({pc, bus.Instruction_i}),
    .dout({bus.Inst_PC_o, bus.Inst_o}),
    .valid(valid),
    .full(full)
  );
endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Upstream neighbour of the program memory: owns the program counter, drives the ROM address, captures each returned instruction with its PC into a small buffer, and presents it to decode over a valid/ready handshake. Branch and jump redirects flush the buffer and reload the PC. The block adds decoupling between fetch and the rest of the datapath, allowing decode to stall without losing instructions.

## Interface
- DATA_WIDTH, 32, instruction and address width
- RESET_VECTOR, 32'h0040_0000, PC value loaded on reset
- FIFO_DEPTH, 2, buffer entries; power of two, minimum 2
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- Address_o  output  DATA_WIDTH  PC to program memory; equals PC register
- Instruction_i  input  DATA_WIDTH  word returned by program memory for Address_o, same cycle
- Redirect_i  input  1  branch/jump taken; flush and reload PC
- Redirect_Target_i  input  DATA_WIDTH  new PC when Redirect_i=1
- Inst_Valid_o  output  1  buffer head valid
- Inst_Ready_i  input  1  decode accepts head this cycle
- Inst_o  output  DATA_WIDTH  head instruction; 0 when empty
- Inst_PC_o  output  DATA_WIDTH  PC of head instruction; 0 when empty
- Misaligned_o  output  1  sticky misaligned-target flag (only with macro; else tied 0)

## Operation
- push = !Redirect_i && !halted && (count<FIFO_DEPTH || pop); pop = Inst_Valid_o && Inst_Ready_i.
- On push: entry {PC, Instruction_i} written at tail; PC <= PC+4.
- PC arithmetic modulo 2^DATA_WIDTH: 32'hFFFF_FFFC+4 -> 32'h0.
- Full and no pop: no push, PC holds, Address_o stable.
- Full with pop: push and pop same cycle, count unchanged.
- Empty: Inst_Valid_o=0, Inst_o=0, Inst_PC_o=0; Inst_Ready_i ignored.
- Redirect_i=1 has priority over push and pop: count <= 0, pointers cleared, PC <= target; no push, pop not counted (head discarded even if Inst_Ready_i=1).
- Consecutive redirects: last one wins; each cycle reloads PC.
- Reset mid-operation: same as power-on; buffered entries discarded.
- Output order strictly FIFO.

## Timing
- Reset values: PC=RESET_VECTOR, Address_o=RESET_VECTOR, count=0, Inst_Valid_o=0, Inst_o=0, Inst_PC_o=0, Misaligned_o=0.
- Latency: instruction at Address_o in cycle N appears at head with Inst_Valid_o=1 in cycle N+1 (buffer empty case).
- After reset release, first instruction (PC=RESET_VECTOR) valid one cycle later.
- After redirect in cycle N: Address_o=target in N+1; target instruction valid in N+2.
- Sustained throughput one instruction per cycle while Inst_Ready_i=1.
- Inst_Valid_o, Inst_o, Inst_PC_o depend only on state (no combinational path from Inst_Ready_i or Redirect_i).

## Configuration
- FETCH_MISALIGN_CHECK_EN defined: Redirect with Redirect_Target_i[1:0]!=0 sets Misaligned_o=1 (sticky until reset), flushes buffer, sets halted; no further pushes, Address_o holds the unaligned target.
- Undefined: Redirect_Target_i[1:0] forced to 2'b00; Misaligned_o tied 0; halted never set.

## Structure
- Shared package fetch_pkg: INST_BYTES=4, DEFAULT_RESET_VECTOR=32'h0040_0000, fetch entry struct {pc, inst}.
- One sub-module: fetch_fifo (synchronous FIFO with flush, count, simultaneous push/pop at full); PC and redirect logic in top.

## Test plan
- Reset release, ROM word k = 32'h1000_0000+k, Inst_Ready_i=1 -> cycle 1 Inst_o=32'h1000_0000, Inst_PC_o=32'h0040_0000; then one per cycle, PC +4.
- Inst_Ready_i=0 for 5 cycles -> count reaches 2, Address_o stuck at 32'h0040_0008; raise ready -> entries 0x..00, 0x..04, 0x..08 in order, none lost or duplicated.
- Redirect_i=1, target 32'h0040_0100 with 2 entries buffered and Inst_Ready_i=1 -> next cycle Inst_Valid_o=0, Address_o=32'h0040_0100; following cycle Inst_PC_o=32'h0040_0100.
- PC at 32'hFFFF_FFFC via redirect -> next PC 32'h0000_0000.
- With macro, redirect target 32'h0040_0102 -> Misaligned_o=1, Inst_Valid_o stays 0 until reset; without macro, fetch proceeds from 32'h0040_0100.
- Assert reset while buffer full -> next cycle all outputs at reset values, Address_o=RESET_VECTOR.
